// File: rtl/cpu_clock_sequencer.sv
// Run/halt/single-step controller for the CPU clock enable.
// A programmable divide counter produces a registered one-cycle cpu_tick, gated by a small FSM.
module cpu_clock_sequencer #(
    parameter int unsigned      DIV_W       = 32,
    parameter logic [DIV_W-1:0] DIV_DEFAULT = DIV_W'(100),
    parameter bit               START_RUN   = 1'b0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             run_req,
    input  logic             halt_req,
    input  logic             step_req,
    input  logic             cpu_halt,
    input  logic             div_load,
    input  logic [DIV_W-1:0] div_value,
    output logic             cpu_tick,
    output logic             step_ack,
    output logic             running,
    output logic [1:0]       state,
    output logic [DIV_W-1:0] div_current,
    output logic [31:0]      tick_count
);

    typedef enum logic [1:0] {
        ST_HALTED = 2'd0,
        ST_RUN    = 2'd1,
        ST_STEP   = 2'd2
    } state_t;

    state_t           r_state;
    logic [DIV_W-1:0] r_counter;
    logic [DIV_W-1:0] r_div_current;
    logic             r_tick;
    logic             r_step_ack;
    logic [31:0]      r_tick_count;

    state_t           w_next_state;
    logic [DIV_W-1:0] w_next_counter;
    logic             w_active;
    logic             w_due;
    logic             w_halt;
    logic             w_issue;
    logic             w_step_issue;

    // A due tick only becomes a real tick if neither a halt nor a divide reload claims the cycle.
    always_comb begin
        w_active       = (r_state == ST_RUN) || (r_state == ST_STEP);
        w_due          = w_active && (r_counter == r_div_current);
        w_halt         = halt_req | cpu_halt;
        w_issue        = w_due & ~w_halt & ~div_load;
        w_step_issue   = w_issue && (r_state == ST_STEP);
        w_next_state   = r_state;
        w_next_counter = r_counter + DIV_W'(1);

        if (w_halt) begin
            w_next_state   = ST_HALTED;
            w_next_counter = '0;
        end else begin
            case (r_state)
                ST_HALTED: begin
                    w_next_counter = '0;
                    if (step_req) begin
                        w_next_state = ST_STEP;
                    end else if (run_req) begin
                        w_next_state = ST_RUN;
                    end
                end
                ST_STEP: begin
                    if (w_due) begin
                        w_next_counter = '0;
                    end
                    if (w_issue) begin
                        w_next_state = ST_HALTED;
                    end
                end
                ST_RUN: begin
                    if (w_due) begin
                        w_next_counter = '0;
                    end
                end
                default: begin
                    w_next_state   = ST_HALTED;
                    w_next_counter = '0;
                end
            endcase
        end

        if (div_load) begin
            w_next_counter = '0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            if (START_RUN) begin
                r_state <= ST_RUN;
            end else begin
                r_state <= ST_HALTED;
            end
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_counter     <= '0;
            r_div_current <= DIV_DEFAULT;
            r_tick        <= 1'b0;
            r_step_ack    <= 1'b0;
            r_tick_count  <= '0;
        end else begin
            r_counter    <= w_next_counter;
            r_tick       <= w_issue;
            r_step_ack   <= w_step_issue;
            r_tick_count <= r_tick_count + 32'(w_issue);
            if (div_load) begin
                r_div_current <= div_value;
            end
        end
    end

    assign cpu_tick    = r_tick;
    assign step_ack    = r_step_ack;
    assign running     = (r_state == ST_RUN);
    assign state       = r_state;
    assign div_current = r_div_current;
    assign tick_count  = r_tick_count;

endmodule

// File: tb/tb_cpu_clock_sequencer.sv
// Directed bench for cpu_clock_sequencer: run, step, divide-by-zero, cpu_halt, reload, async reset.
// Cycle cN begins at a posedge; inputs are driven and outputs sampled 1 ns after that edge.
module tb_cpu_clock_sequencer;

    logic        clock;
    logic        reset;
    logic        run_req;
    logic        halt_req;
    logic        step_req;
    logic        cpu_halt;
    logic        div_load;
    logic [31:0] div_value;
    logic        cpu_tick;
    logic        step_ack;
    logic        running;
    logic [1:0]  state;
    logic [31:0] div_current;
    logic [31:0] tick_count;

    int checks;
    int errors;

    cpu_clock_sequencer #(
        .DIV_W      (32),
        .DIV_DEFAULT(32'd3),
        .START_RUN  (1'b0)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .run_req    (run_req),
        .halt_req   (halt_req),
        .step_req   (step_req),
        .cpu_halt   (cpu_halt),
        .div_load   (div_load),
        .div_value  (div_value),
        .cpu_tick   (cpu_tick),
        .step_ack   (step_ack),
        .running    (running),
        .state      (state),
        .div_current(div_current),
        .tick_count (tick_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        reset     = 1'b1;
        run_req   = 1'b0;
        halt_req  = 1'b0;
        step_req  = 1'b0;
        cpu_halt  = 1'b0;
        div_load  = 1'b0;
        div_value = 32'd0;

        #12;
        check("rst_state", 32'(state), 32'd0);
        check("rst_tick", 32'(cpu_tick), 32'd0);
        check("rst_ack", 32'(step_ack), 32'd0);
        check("rst_running", 32'(running), 32'd0);
        check("rst_div", div_current, 32'd3);
        check("rst_count", tick_count, 32'd0);
        reset = 1'b0;
        next_cycle();

        // Free run at div 3: ticks c5, c9, c13
        run_req = 1'b1;
        for (int c = 0; c <= 13; c++) begin
            check("run_tick", 32'(cpu_tick), 32'(c == 5 || c == 9 || c == 13));
            if (c >= 1) check("run_state", 32'(state), 32'd1);
            next_cycle();
            run_req = 1'b0;
        end
        check("run_count", tick_count, 32'd3);
        check("run_running", 32'(running), 32'd1);
        halt_req = 1'b1;
        next_cycle();
        halt_req = 1'b0;
        check("halt_state", 32'(state), 32'd0);
        next_cycle();
        next_cycle();
        check("halt_count", tick_count, 32'd3);

        // Single step: one tick + ack at c5, halted at c5, nothing at c9
        step_req = 1'b1;
        for (int c = 0; c <= 9; c++) begin
            check("step_tick", 32'(cpu_tick), 32'(c == 5));
            check("step_ack", 32'(step_ack), 32'(c == 5));
            check("step_state", 32'(state), (c >= 1 && c <= 4) ? 32'd2 : 32'd0);
            next_cycle();
            step_req = 1'b0;
        end
        check("step_count", tick_count, 32'd4);

        // step_req and run_req together: step wins
        step_req = 1'b1;
        run_req  = 1'b1;
        next_cycle();
        step_req = 1'b0;
        run_req  = 1'b0;
        check("both_state", 32'(state), 32'd2);
        for (int c = 1; c < 5; c++) next_cycle();
        check("both_tick", 32'(cpu_tick), 32'd1);
        check("both_state_end", 32'(state), 32'd0);
        check("both_count", tick_count, 32'd5);
        next_cycle();

        // Divide by zero: tick every cycle from c2; halt_req at c10
        div_load  = 1'b1;
        div_value = 32'd0;
        next_cycle();
        div_load = 1'b0;
        check("div0_load", div_current, 32'd0);
        run_req = 1'b1;
        for (int c = 0; c <= 13; c++) begin
            check("div0_tick", 32'(cpu_tick), 32'(c >= 2 && c <= 10));
            if (c == 10) halt_req = 1'b1;
            next_cycle();
            halt_req = 1'b0;
            run_req  = 1'b0;
        end
        check("div0_count", tick_count, 32'd14);
        check("div0_state", 32'(state), 32'd0);

        // cpu_halt held from c6 overrides run_req at c8
        div_load  = 1'b1;
        div_value = 32'd3;
        next_cycle();
        div_load = 1'b0;
        for (int c = 0; c <= 14; c++) begin
            if (c == 6) cpu_halt = 1'b1;
            run_req = (c == 0 || c == 8);
            check("chalt_tick", 32'(cpu_tick), 32'(c == 5));
            check("chalt_state", 32'(state), (c >= 1 && c <= 6) ? 32'd1 : 32'd0);
            next_cycle();
        end
        run_req  = 1'b0;
        cpu_halt = 1'b0;
        next_cycle();
        check("chalt_state_end", 32'(state), 32'd0);
        check("chalt_count", tick_count, 32'd15);

        // Reload in RUN: div 1 at c2, then div 2 at c12 drops a due tick; step_req at c14 ignored
        for (int c = 0; c <= 17; c++) begin
            run_req   = (c == 0);
            step_req  = (c == 14);
            div_load  = (c == 2 || c == 12);
            div_value = (c == 2) ? 32'd1 : 32'd2;
            check("load_tick", 32'(cpu_tick), 32'(((c >= 5) && (c <= 11) && (c % 2 == 1)) || c == 16));
            next_cycle();
        end
        run_req  = 1'b0;
        step_req = 1'b0;
        div_load = 1'b0;
        check("load_div", div_current, 32'd2);
        check("load_state", 32'(state), 32'd1);
        check("load_count", tick_count, 32'd20);

        // Asynchronous reset mid-cycle while ticking every cycle
        div_load  = 1'b1;
        div_value = 32'd0;
        next_cycle();
        div_load = 1'b0;
        next_cycle();
        next_cycle();
        check("pre_rst_tick", 32'(cpu_tick), 32'd1);
        #3;
        reset = 1'b1;
        #1;
        check("arst_tick", 32'(cpu_tick), 32'd0);
        check("arst_count", tick_count, 32'd0);
        check("arst_state", 32'(state), 32'd0);
        check("arst_div", div_current, 32'd3);
        next_cycle();
        reset = 1'b0;
        next_cycle();
        check("post_rst_state", 32'(state), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
